// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller for a 5-stage CPU: per-stage enables/flushes,
// load-use bubbles, branch flushes, data-memory wait with timeout, halt/drain.
module pipe_ctrl #(
  parameter int unsigned WAIT_MAX  = 15,
  parameter int unsigned DRAIN_CYC = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [4:0]  D_Rs,
  input  logic [4:0]  D_Rt,
  input  logic        D_UseRt,
  input  logic        E_MemRd,
  input  logic [4:0]  E_Rw,
  input  logic        E_BrTaken,
  input  logic        M_MemReq,
  input  logic        MemAck,
  input  logic        Halt,
  output logic        PC_En,
  output logic        FD_En,
  output logic        DE_En,
  output logic        EM_En,
  output logic        MW_En,
  output logic        FD_Flush,
  output logic        DE_Flush,
  output logic        MW_Flush,
  output logic        MemErr,
  output logic        Halted,
  output logic [15:0] StallCnt
);

  localparam logic [2:0] ST_RUN    = 3'd0;
  localparam logic [2:0] ST_WAIT   = 3'd1;
  localparam logic [2:0] ST_DRAIN  = 3'd2;
  localparam logic [2:0] ST_HALTED = 3'd3;
  localparam logic [2:0] ST_ERROR  = 3'd4;

  localparam logic [7:0] WAIT_LAST  = 8'(WAIT_MAX);
  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_CYC);

  logic [2:0]  state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [7:0]  drain_cnt_q, drain_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        mem_err_q, mem_err_d;

  logic memstall;
  logic loaduse;

  assign memstall = M_MemReq & ~MemAck;
  assign loaduse  = E_MemRd & (E_Rw != 5'd0) &
                    ((E_Rw == D_Rs) | (D_UseRt & (E_Rw == D_Rt)));

  always_comb begin
    PC_En       = 1'b0;
    FD_En       = 1'b0;
    DE_En       = 1'b0;
    EM_En       = 1'b0;
    MW_En       = 1'b0;
    FD_Flush    = 1'b0;
    DE_Flush    = 1'b0;
    MW_Flush    = 1'b0;
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    drain_cnt_d = drain_cnt_q;
    mem_err_d   = mem_err_q;

    case (state_q)
      ST_RUN: begin
        if (memstall) begin
          MW_En      = 1'b1;
          MW_Flush   = 1'b1;
          state_d    = ST_WAIT;
          wait_cnt_d = 8'd1;
        end else if (E_BrTaken) begin
          PC_En    = 1'b1;
          FD_En    = 1'b1;
          DE_En    = 1'b1;
          EM_En    = 1'b1;
          MW_En    = 1'b1;
          FD_Flush = 1'b1;
          DE_Flush = 1'b1;
        end else if (loaduse) begin
          DE_En    = 1'b1;
          EM_En    = 1'b1;
          MW_En    = 1'b1;
          DE_Flush = 1'b1;
        end else if (Halt) begin
          FD_En       = 1'b1;
          DE_En       = 1'b1;
          EM_En       = 1'b1;
          MW_En       = 1'b1;
          FD_Flush    = 1'b1;
          state_d     = ST_DRAIN;
          drain_cnt_d = 8'd1;
        end else begin
          PC_En = 1'b1;
          FD_En = 1'b1;
          DE_En = 1'b1;
          EM_En = 1'b1;
          MW_En = 1'b1;
        end
      end

      ST_WAIT: begin
        if (memstall) begin
          MW_En    = 1'b1;
          MW_Flush = 1'b1;
          if (wait_cnt_q == WAIT_LAST) begin
            mem_err_d = 1'b1;
            state_d   = ST_ERROR;
          end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
        end else begin
          // Access finished: resolve any branch/load-use waiting behind it now.
          state_d    = ST_RUN;
          wait_cnt_d = 8'd0;
          DE_En      = 1'b1;
          EM_En      = 1'b1;
          MW_En      = 1'b1;
          if (E_BrTaken) begin
            PC_En    = 1'b1;
            FD_En    = 1'b1;
            FD_Flush = 1'b1;
            DE_Flush = 1'b1;
          end else if (loaduse) begin
            DE_Flush = 1'b1;
          end else begin
            PC_En = 1'b1;
            FD_En = 1'b1;
          end
        end
      end

      ST_DRAIN: begin
        if (memstall) begin
          MW_En    = 1'b1;
          MW_Flush = 1'b1;
          if (wait_cnt_q == WAIT_LAST) begin
            mem_err_d = 1'b1;
            state_d   = ST_ERROR;
          end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
        end else begin
          FD_En      = 1'b1;
          DE_En      = 1'b1;
          EM_En      = 1'b1;
          MW_En      = 1'b1;
          FD_Flush   = 1'b1;
          wait_cnt_d = 8'd0;
          if (drain_cnt_q == DRAIN_LAST) begin
            state_d = ST_HALTED;
          end else begin
            drain_cnt_d = drain_cnt_q + 8'd1;
          end
        end
      end

      ST_HALTED, ST_ERROR: begin
      end

      default: state_d = ST_RUN;
    endcase

    if (Reset) begin
      PC_En    = 1'b0;
      FD_En    = 1'b0;
      DE_En    = 1'b0;
      EM_En    = 1'b0;
      MW_En    = 1'b0;
      FD_Flush = 1'b0;
      DE_Flush = 1'b0;
      MW_Flush = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (((state_q == ST_RUN) || (state_q == ST_WAIT)) && !PC_En &&
        (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= 8'd0;
      drain_cnt_q <= 8'd0;
      stall_cnt_q <= 16'd0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      mem_err_q   <= mem_err_d;
    end
  end

  assign MemErr   = mem_err_q;
  assign Halted   = (state_q == ST_HALTED);
  assign StallCnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus random traffic,
// all compared against a cycle-level behavioural model of the controller.
module tb_pipe_ctrl;

  localparam int WAIT_MAX  = 15;
  localparam int DRAIN_CYC = 4;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [4:0]  D_Rs, D_Rt, E_Rw;
  logic        D_UseRt, E_MemRd, E_BrTaken, M_MemReq, MemAck, Halt;
  logic        PC_En, FD_En, DE_En, EM_En, MW_En;
  logic        FD_Flush, DE_Flush, MW_Flush, MemErr, Halted;
  logic [15:0] StallCnt;

  always #5 Clk = ~Clk;

  pipe_ctrl #(.WAIT_MAX(WAIT_MAX), .DRAIN_CYC(DRAIN_CYC)) dut (
    .Clk(Clk), .Reset(Reset), .D_Rs(D_Rs), .D_Rt(D_Rt), .D_UseRt(D_UseRt),
    .E_MemRd(E_MemRd), .E_Rw(E_Rw), .E_BrTaken(E_BrTaken), .M_MemReq(M_MemReq),
    .MemAck(MemAck), .Halt(Halt), .PC_En(PC_En), .FD_En(FD_En), .DE_En(DE_En),
    .EM_En(EM_En), .MW_En(MW_En), .FD_Flush(FD_Flush), .DE_Flush(DE_Flush),
    .MW_Flush(MW_Flush), .MemErr(MemErr), .Halted(Halted), .StallCnt(StallCnt)
  );

  // Output patterns {PC,FD,DE,EM,MW enables, FD,DE,MW flushes}
  localparam logic [7:0] V_FREEZE = 8'b00001_001;
  localparam logic [7:0] V_FLUSH  = 8'b11111_110;
  localparam logic [7:0] V_BUBBLE = 8'b00111_010;
  localparam logic [7:0] V_DRAIN  = 8'b01111_100;
  localparam logic [7:0] V_GO     = 8'b11111_000;

  localparam int M_RUN = 0, M_WAIT = 1, M_DRAIN = 2, M_HALT = 3, M_ERR = 4;

  int   m_mode = M_RUN;
  int   m_consec = 0;    // consecutive stalled memory cycles
  int   m_bubbles = 0;   // halt bubbles issued so far
  int   m_stalls = 0;
  logic m_err = 1'b0;

  int total = 0;
  int bad = 0;

  function automatic logic [9:0] model_out();
    logic ms, lu;
    logic [7:0] v;
    ms = M_MemReq && !MemAck;
    lu = E_MemRd && (E_Rw != 0) && ((E_Rw == D_Rs) || (D_UseRt && (E_Rw == D_Rt)));
    v = 8'h00;
    if (!Reset) begin
      if (m_mode == M_RUN)
        v = ms ? V_FREEZE : E_BrTaken ? V_FLUSH : lu ? V_BUBBLE : Halt ? V_DRAIN : V_GO;
      else if (m_mode == M_WAIT)
        v = ms ? V_FREEZE : E_BrTaken ? V_FLUSH : lu ? V_BUBBLE : V_GO;
      else if (m_mode == M_DRAIN)
        v = ms ? V_FREEZE : V_DRAIN;
    end
    return {v, (m_mode == M_HALT), m_err};
  endfunction

  task automatic model_commit(input logic pc_exp);
    logic ms, lu;
    ms = M_MemReq && !MemAck;
    lu = E_MemRd && (E_Rw != 0) && ((E_Rw == D_Rs) || (D_UseRt && (E_Rw == D_Rt)));
    if (Reset) begin
      m_mode = M_RUN; m_consec = 0; m_bubbles = 0; m_stalls = 0; m_err = 1'b0;
      return;
    end
    if ((m_mode == M_RUN || m_mode == M_WAIT) && !pc_exp && m_stalls < 65535)
      m_stalls++;
    case (m_mode)
      M_RUN: begin
        if (ms) begin m_mode = M_WAIT; m_consec = 1; end
        else if (!E_BrTaken && !lu && Halt) begin m_mode = M_DRAIN; m_bubbles = 1; end
      end
      M_WAIT, M_DRAIN: begin
        if (ms) begin
          m_consec++;
          if (m_consec == WAIT_MAX + 1) begin m_err = 1'b1; m_mode = M_ERR; end
        end else begin
          m_consec = 0;
          if (m_mode == M_WAIT) m_mode = M_RUN;
          else begin
            m_bubbles++;
            if (m_bubbles == DRAIN_CYC + 1) m_mode = M_HALT;
          end
        end
      end
      default: ;
    endcase
  endtask

  function automatic logic [9:0] observed();
    return {PC_En, FD_En, DE_En, EM_En, MW_En, FD_Flush, DE_Flush, MW_Flush, Halted, MemErr};
  endfunction

  task automatic advance(input logic [9:0] e);
    @(posedge Clk);
    #1;
    model_commit(e[9]);
  endtask

  task automatic idle();
    Reset = 0; D_Rs = 0; D_Rt = 0; D_UseRt = 0; E_MemRd = 0; E_Rw = 0;
    E_BrTaken = 0; M_MemReq = 0; MemAck = 0; Halt = 0;
  endtask

  task automatic do_reset();
    logic [9:0] e;
    idle();
    Reset = 1;
    @(negedge Clk);
    e = model_out();
    advance(e);
    Reset = 0;
  endtask

  task automatic test_reset();
    logic [9:0] e;
    for (int i = 0; i < 4; i++) begin
      Reset = 1; D_Rs = 5'($urandom); D_Rt = 5'($urandom); E_Rw = D_Rs;
      D_UseRt = 1'($urandom); E_MemRd = 1; E_BrTaken = 1'($urandom);
      M_MemReq = 1'($urandom); MemAck = 0; Halt = 1'($urandom);
      @(negedge Clk);
      e = model_out();
      total++;
      if (observed() !== e || StallCnt !== 16'(m_stalls)) begin
        bad++;
        $display("FAIL reset cyc%0d: got out=%b stall=%0d, want out=%b stall=%0d",
                 i, observed(), StallCnt, e, m_stalls);
      end
      advance(e);
    end
    idle();
  endtask

  task automatic test_load_use();
    logic [9:0] e;
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      for (int i = 0; i < 3; i++) begin
        idle();
        if (i == 0) begin E_MemRd = 1; E_Rw = (pass == 0) ? 5'd5 : 5'd0; D_Rs = E_Rw; end
        @(negedge Clk);
        e = model_out();
        total++;
        if (observed() !== e || StallCnt !== 16'(m_stalls)) begin
          bad++;
          $display("FAIL load_use p%0d cyc%0d: got out=%b stall=%0d, want out=%b stall=%0d",
                   pass, i, observed(), StallCnt, e, m_stalls);
        end
        advance(e);
      end
      total++;
      if (StallCnt !== ((pass == 0) ? 16'd1 : 16'd0)) begin
        bad++;
        $display("FAIL load_use_count p%0d: got %0d want %0d", pass, StallCnt, (pass == 0) ? 1 : 0);
      end
    end
  endtask

  task automatic test_branch_vs_loaduse();
    logic [9:0] e;
    do_reset();
    idle();
    E_MemRd = 1; E_Rw = 5'd9; D_Rt = 5'd9; D_UseRt = 1; E_BrTaken = 1; Halt = 1;
    @(negedge Clk);
    e = model_out();
    total++;
    if (observed() !== e || e[9:2] !== V_FLUSH) begin
      bad++;
      $display("FAIL branch_vs_loaduse: got out=%b, want out=%b", observed(), e);
    end
    advance(e);
    idle();
    total++;
    if (StallCnt !== 16'd0) begin
      bad++;
      $display("FAIL branch_stallcnt: got %0d want 0", StallCnt);
    end
  endtask

  task automatic test_mem_wait();
    logic [9:0] e;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      idle();
      M_MemReq = (i < 4); MemAck = (i == 3); Halt = (i < 4);
      if (i == 3) E_BrTaken = 1;
      @(negedge Clk);
      e = model_out();
      total++;
      if (observed() !== e || StallCnt !== 16'(m_stalls)) begin
        bad++;
        $display("FAIL mem_wait cyc%0d: got out=%b stall=%0d, want out=%b stall=%0d",
                 i, observed(), StallCnt, e, m_stalls);
      end
      advance(e);
    end
    idle();
    total++;
    if (StallCnt !== 16'd3 || Halted !== 1'b0) begin
      bad++;
      $display("FAIL mem_wait_count: got stall=%0d halted=%b want 3/0", StallCnt, Halted);
    end
  endtask

  task automatic test_timeout();
    logic [9:0] e;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      idle();
      M_MemReq = 1; MemAck = (i >= 18);
      @(negedge Clk);
      e = model_out();
      total++;
      if (observed() !== e || StallCnt !== 16'(m_stalls)) begin
        bad++;
        $display("FAIL timeout cyc%0d: got out=%b stall=%0d, want out=%b stall=%0d",
                 i, observed(), StallCnt, e, m_stalls);
      end
      advance(e);
    end
    total++;
    if (MemErr !== 1'b1 || StallCnt !== 16'd16) begin
      bad++;
      $display("FAIL timeout_err: got err=%b stall=%0d want 1/16", MemErr, StallCnt);
    end
    do_reset();
    total++;
    if (MemErr !== 1'b0) begin
      bad++;
      $display("FAIL timeout_clear: got err=%b want 0", MemErr);
    end
  endtask

  task automatic test_halt();
    logic [9:0] e;
    int drains;
    drains = 0;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      idle();
      Halt = (i == 0);
      E_BrTaken = (i == 7);
      @(negedge Clk);
      e = model_out();
      if (PC_En === 1'b0 && FD_Flush === 1'b1) drains++;
      total++;
      if (observed() !== e) begin
        bad++;
        $display("FAIL halt cyc%0d: got out=%b, want out=%b", i, observed(), e);
      end
      advance(e);
    end
    total++;
    if (drains != DRAIN_CYC + 1 || Halted !== 1'b1) begin
      bad++;
      $display("FAIL halt_drain: got bubbles=%0d halted=%b want %0d/1", drains, Halted, DRAIN_CYC + 1);
    end
  endtask

  task automatic test_reset_mid_drain();
    logic [9:0] e;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      idle();
      Halt = (i == 0);
      Reset = (i == 2);
      @(negedge Clk);
      e = model_out();
      total++;
      if (observed() !== e || StallCnt !== 16'(m_stalls)) begin
        bad++;
        $display("FAIL reset_mid_drain cyc%0d: got out=%b stall=%0d, want out=%b stall=%0d",
                 i, observed(), StallCnt, e, m_stalls);
      end
      advance(e);
    end
  endtask

  task automatic test_random();
    logic [9:0] e;
    for (int seg = 0; seg < 8; seg++) begin
      do_reset();
      for (int i = 0; i < 150; i++) begin
        Reset     = ($urandom_range(0, 79) == 0);
        D_Rs      = 5'($urandom_range(0, 7));
        D_Rt      = 5'($urandom_range(0, 7));
        D_UseRt   = 1'($urandom);
        E_MemRd   = ($urandom_range(0, 2) == 0);
        E_Rw      = 5'($urandom_range(0, 7));
        E_BrTaken = ($urandom_range(0, 5) == 0);
        M_MemReq  = ($urandom_range(0, 3) == 0) || (m_mode == M_WAIT && $urandom_range(0, 3) != 0);
        MemAck    = ($urandom_range(0, 2) == 0);
        Halt      = ($urandom_range(0, 29) == 0);
        @(negedge Clk);
        e = model_out();
        total++;
        if (observed() !== e || StallCnt !== 16'(m_stalls)) begin
          bad++;
          $display("FAIL random s%0d c%0d: got out=%b stall=%0d, want out=%b stall=%0d",
                   seg, i, observed(), StallCnt, e, m_stalls);
        end
        advance(e);
      end
    end
    idle();
  endtask

  initial begin
    idle();
    Reset = 1;
    @(posedge Clk);
    #1;
    model_commit(1'b0);
    test_reset();
    test_load_use();
    test_branch_vs_loaduse();
    test_mem_wait();
    test_timeout();
    test_halt();
    test_reset_mid_drain();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage (IF/ID/EX/MEM/WB) CPU datapath.
- Generates per-stage register enables and flush (bubble) controls.
- Handles load-use stalls, taken-branch flushes, multi-cycle data-memory waits with timeout, and a halt/drain sequence.
- Works alongside the EX-stage forwarding unit, which covers all RAW cases except load-use.

Parameters:
- WAIT_MAX, 15: maximum consecutive MEM wait cycles before an error is declared; legal range 1..255.
- DRAIN_CYC, 4: bubble cycles issued after Halt before entering HALTED.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  synchronous reset, active-high.
- D_Rs  input  5  ID-stage instruction first source register.
- D_Rt  input  5  ID-stage instruction second source register.
- D_UseRt  input  1  ID-stage instruction reads Rt.
- E_MemRd  input  1  EX-stage instruction is a load.
- E_Rw  input  5  EX-stage destination register.
- E_BrTaken  input  1  EX-stage branch/jump resolved taken.
- M_MemReq  input  1  MEM-stage instruction accesses data memory.
- MemAck  input  1  data memory completes the access this cycle.
- Halt  input  1  halt request, sampled in RUN only.
- PC_En  output  1  PC update enable.
- FD_En  output  1  IF/ID register enable.
- DE_En  output  1  ID/EX register enable.
- EM_En  output  1  EX/MEM register enable.
- MW_En  output  1  MEM/WB register enable.
- FD_Flush  output  1  IF/ID loads a bubble.
- DE_Flush  output  1  ID/EX loads a bubble.
- MW_Flush  output  1  MEM/WB loads a bubble.
- MemErr  output  1  sticky memory-timeout flag.
- Halted  output  1  high in the HALTED state.
- StallCnt  output  16  saturating count of cycles with PC_En=0 in RUN or WAIT.

Behaviour:
- Reset: while Reset=1, all enables=0, all flushes=0. On the clock edge, state←RUN and wait_cnt, drain_cnt, StallCnt, MemErr←0. Reset mid-operation aborts any state immediately; no clock enable or flush is issued.
- Outputs are combinational from state and inputs (Mealy). state, counters and MemErr are registered.
- Definitions:
  - memstall = M_MemReq & ~MemAck
  - loaduse = E_MemRd & (E_Rw≠0) & ((E_Rw==D_Rs) | (D_UseRt & (E_Rw==D_Rt)))
- RUN. Priority order, highest first:
  1. memstall: PC/FD/DE/EM_En=0, MW_En=1, MW_Flush=1, all other flushes 0. Next state WAIT, wait_cnt←1.
  2. E_BrTaken: all enables=1, FD_Flush=1, DE_Flush=1. Branch wins over loaduse and Halt in the same cycle.
  3. loaduse: PC_En=0, FD_En=0, DE_En=1, DE_Flush=1, EM_En=1, MW_En=1. Exactly one bubble per occurrence.
  4. Halt: PC_En=0, FD_En=1, FD_Flush=1, other enables=1. Next state DRAIN, drain_cnt←1.
  5. Otherwise: all enables=1, all flushes=0.
- WAIT: outputs as in the RUN memstall row while memstall holds.
  - If MemAck=1: all enables=1 and any pending E_BrTaken/loaduse is evaluated with RUN priorities 2–3 in that same cycle. Next state RUN, wait_cnt←0.
  - Else if wait_cnt==WAIT_MAX: MemErr←1, next state ERROR. Else wait_cnt increments.
  - Halt is ignored in WAIT.
- DRAIN: PC_En=0, FD_En=1, FD_Flush=1, DE/EM/MW_En=1.
  - memstall freezes as in WAIT but does not advance drain_cnt; timeout rules apply.
  - When drain_cnt==DRAIN_CYC, next state HALTED; else drain_cnt increments.
- HALTED: all enables=0, Halted=1. Exit only via Reset.
- ERROR: all enables=0, MemErr=1. Exit only via Reset.
- StallCnt increments on each cycle where state∈{RUN,WAIT} and PC_En=0. It saturates at 16'hFFFF.
- A simultaneous MemAck and E_BrTaken in WAIT produces a flush with all enables=1 in that cycle.

Test Plan:
- Load-use: E_MemRd=1, E_Rw=5, D_Rs=5 for one cycle → PC_En=0, FD_En=0, DE_Flush=1 for exactly 1 cycle; StallCnt=1. Repeat with E_Rw=0 → no stall.
- Branch vs load-use: E_BrTaken=1 and loaduse true in the same cycle → PC_En=1, FD_Flush=1, DE_Flush=1, no stall; StallCnt unchanged.
- Memory wait: M_MemReq=1, MemAck=0 for 3 cycles, then MemAck=1 → 3 cycles with PC/FD/DE/EM_En=0 and MW_Flush=1; 4th cycle all enables=1; StallCnt=3.
- Timeout: WAIT_MAX=15, MemAck held 0 → MemErr rises after the 16th stalled cycle, state ERROR, enables stay 0 until Reset; Reset clears MemErr.
- Halt: Halt=1 in RUN → 1 cycle in RUN plus DRAIN_CYC=4 cycles of FD_Flush=1 with PC_En=0, then Halted=1 with all enables=0; Halt asserted during WAIT is ignored.
- Reset mid-DRAIN (drain_cnt=2) → next cycle state RUN, all counters 0, Halted=0.
